register_file: RTL

Integer register file for the core's decode stage. It holds x1..x31 and provides two registered read ports, which are the operand source values the forwarding logic overrides with in-flight execute results. It has one write port from writeback with write-through bypass. Storage is RAM-friendly and cannot be reset in parallel, so an internal clear sequencer zeroes the array after reset and holds `ready` low until the sweep finishes.

---
 rtl/register_file.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/register_file.sv
// Decode-stage integer register file: x1..x31, two registered read ports,
// one write port with write-through bypass, and a post-reset clear sweep.
module register_file #(
    parameter int XLEN = 32,
    parameter int REGS = 32,
    localparam int AW  = $clog2(REGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            rden1,
    input  logic [AW-1:0]   raddr1,
    input  logic            rden2,
    input  logic [AW-1:0]   raddr2,
    input  logic            wren,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_REG  = AW'(REGS - 1);
    localparam logic [AW-1:0] FIRST_REG = AW'(1);

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2_q, rdata2_d;
    logic [AW-1:0]     raddr1_q, raddr1_d;
    logic [AW-1:0]     raddr2_q, raddr2_d;
    logic              rden1_q, rden1_d;
    logic              rden2_q, rden2_d;

    logic [XLEN-1:0]   mem [REGS];
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [XLEN-1:0]   mem_wd;
    logic              wr_live;

    // Resolves one read port: disabled or x0 reads give zero, a same-cycle
    // write to the addressed register is forwarded ahead of the array.
    function automatic logic [XLEN-1:0] read_port(input logic en,
                                                  input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (!en || addr == '0) begin
            val = '0;
        end else if (wren && waddr == addr) begin
            val = wdata;
        end else begin
            val = mem[addr];
        end
        return val;
    endfunction

    assign wr_live = wren && (waddr != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        rden1_d  = rden1_q;
        rden2_d  = rden2_q;
        mem_we   = 1'b0;
        mem_wa   = waddr;
        mem_wd   = wdata;

        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST_REG) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                mem_we = wr_live;
                if (!stall) begin
                    raddr1_d = raddr1;
                    raddr2_d = raddr2;
                    rden1_d  = rden1;
                    rden2_d  = rden2;
                    rdata1_d = read_port(rden1, raddr1);
                    rdata2_d = read_port(rden2, raddr2);
                end else begin
                    // Held operands track writes to the register they name.
                    if (wr_live && rden1_q && waddr == raddr1_q) rdata1_d = wdata;
                    if (wr_live && rden2_q && waddr == raddr2_q) rdata2_d = wdata;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= FIRST_REG;
            ready_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            rden1_q  <= 1'b0;
            rden2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            rden1_q  <= rden1_d;
            rden2_q  <= rden2_d;
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign ready  = ready_q;

endmodule
